// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared state encodings, mode codes and operand width for operand_loader
package operand_loader_pkg;

  localparam int OPERAND_W = 4;

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_MODE  = 2'b10,
    S_READY = 2'b11
  } state_t;

  localparam logic [1:0] SCOMP_UNSIGNED = 2'b10;
  localparam logic [1:0] SCOMP_SIGNED   = 2'b11;

endpackage

// File: rtl/operand_loader_key_debounce.sv
// rtl/operand_loader_key_debounce.sv - key synchronizer, debouncer and falling-edge press pulse
// Debounce counter present only when OPERAND_LOADER_DEBOUNCE_EN is defined.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Any bounce back to the accepted level restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic unused_debounce_cycles;

  assign level                  = sync2;
  assign unused_debounce_cycles = (DEBOUNCE_CYCLES > 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b1;
    end else begin
      level_d <= level;
    end
  end

  // One-cycle pulse on the accepted 1->0 transition only; releases are silent.
  assign press = level_d & ~level;

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - button-stepped capture of two operands and comparison mode
// Debounce behaviour selected by OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 MAX10_CLK1_50,
  input  logic                 RESET,
  input  logic                 KEY_N,
  input  logic [OPERAND_W-1:0] SW,
  output logic [OPERAND_W-1:0] input1,
  output logic [OPERAND_W-1:0] input2,
  output logic [1:0]           scomp,
  output logic                 valid,
  output logic [1:0]           stage
);

  state_t state;
  logic   press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (MAX10_CLK1_50),
    .rst   (RESET),
    .key_n (KEY_N),
    .press (press)
  );

  // valid rises on the same edge scomp is written, so all three agree while it is high.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RESET) begin
      state  <= S_A;
      input1 <= '0;
      input2 <= '0;
      scomp  <= SCOMP_UNSIGNED;
      valid  <= 1'b0;
    end else if (press) begin
      case (state)
        S_A: begin
          input1 <= SW;
          state  <= S_B;
        end
        S_B: begin
          input2 <= SW;
          state  <= S_MODE;
        end
        S_MODE: begin
          scomp <= {1'b1, SW[0]};
          valid <= 1'b1;
          state <= S_READY;
        end
        S_READY: begin
          valid <= 1'b0;
          state <= S_A;
        end
      endcase
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - scoreboard bench for operand_loader, either debounce build
module tb_operand_loader;

  localparam int D = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = D + 3;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif
  localparam int GAP = 2 * D + 6;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       KEY_N = 1'b1;
  logic [3:0] SW = 4'h0;
  logic [3:0] input1;
  logic [3:0] input2;
  logic [1:0] scomp;
  logic       valid;
  logic [1:0] stage;

  operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .MAX10_CLK1_50 (clk),
    .RESET         (RESET),
    .KEY_N         (KEY_N),
    .SW            (SW),
    .input1        (input1),
    .input2        (input2),
    .scomp         (scomp),
    .valid         (valid),
    .stage         (stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  i1;
    logic [3:0]  i2;
    logic [1:0]  sc;
    logic        v;
    logic [1:0]  st;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [1:0]  prev_stage = 2'b00;

  logic [1:0] m_st = 2'b00;
  logic [3:0] m_i1 = 4'h0;
  logic [3:0] m_i2 = 4'h0;
  logic [1:0] m_sc = 2'b10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 2'b00;
    m_i1 = 4'h0;
    m_i2 = 4'h0;
    m_sc = 2'b10;
  endtask

  task automatic model_press(input int unsigned at);
    exp_t e;
    case (m_st)
      2'b00:   m_i1 = SW;
      2'b01:   m_i2 = SW;
      2'b10:   m_sc = {1'b1, SW[0]};
      default: ;
    endcase
    m_st = m_st + 2'b01;
    e.i1 = m_i1;
    e.i2 = m_i2;
    e.sc = m_sc;
    e.v  = (m_st == 2'b11);
    e.st = m_st;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESET = 1'b1;
    KEY_N = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic do_press(input logic [3:0] sw, input int hold);
    @(negedge clk);
    SW    = sw;
    KEY_N = 1'b0;
    model_press(cyc + LAT);
    repeat (hold) @(negedge clk);
    KEY_N = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] i1, input logic [3:0] i2,
                               input logic [1:0] sc, input logic v, input logic [1:0] st);
    check({tag, "_input1"}, input1, i1);
    check({tag, "_input2"}, input2, i2);
    check({tag, "_scomp"},  scomp,  sc);
    check({tag, "_valid"},  valid,  v);
    check({tag, "_stage"},  stage,  st);
  endtask

  // Monitor: every non-reset stage change must match the next scoreboard entry.
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #2;
    if (RESET) begin
      prev_stage = stage;
    end else if (stage !== prev_stage) begin
      prev_stage = stage;
      check("capture_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("cap_latency", cyc, e.at);
        check_outputs("cap", e.i1, e.i2, e.sc, e.v, e.st);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached, expected finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;

    // Reset held two cycles.
    do_reset();
    check_outputs("reset", 4'h0, 4'h0, 2'b10, 1'b0, 2'b00);

    // Three clean presses fill the operands and mode.
    do_press(4'b0101, D + 6);
    do_press(4'b1110, D + 6);
    do_press(4'b0001, D + 6);
    check_outputs("ready", 4'h5, 4'hE, 2'b11, 1'b1, 2'b11);

    // Press in S_READY only drops valid and returns to S_A.
    do_press(4'b1111, D + 6);
    check_outputs("wrap", 4'h5, 4'hE, 2'b11, 1'b0, 2'b00);

    // Bounce 0/1/0 then long hold.
    @(negedge clk);
    SW    = 4'b0011;
    KEY_N = 1'b0;
    if (!DEB) model_press(cyc + LAT);
    @(negedge clk);
    KEY_N = 1'b1;
    @(negedge clk);
    KEY_N = 1'b0;
    model_press(cyc + LAT);
    repeat (20) @(negedge clk);
    KEY_N = 1'b1;
    repeat (GAP) @(negedge clk);
    check("bounce_stage", stage, DEB ? 2'b01 : 2'b10);
    check("bounce_input1", input1, 4'h3);

    // Reset on the capture edge in S_B wins.
    do_reset();
    check_outputs("reset2", 4'h0, 4'h0, 2'b10, 1'b0, 2'b00);
    do_press(4'h7, D + 6);
    @(negedge clk);
    SW    = 4'h9;
    KEY_N = 1'b0;
    n     = cyc;
    while (cyc < n + LAT - 1) @(negedge clk);
    RESET = 1'b1;
    KEY_N = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    model_reset();
    repeat (GAP) @(negedge clk);
    check_outputs("reset_race", 4'h0, 4'h0, 2'b10, 1'b0, 2'b00);

    check("sb_pending", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream input stage for the two-operand magnitude comparator. It converts one noisy pushbutton and four slide switches into three stable registered values: operand 1, operand 2 and the comparison mode. These drive the comparator's `input1`, `input2` and `scomp` inputs directly. A four-state sequencer steps through the captures one press at a time. `valid` flags the cycle range in which all three values are final.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new button level (10 ms at 50 MHz); must be ≥ 2.

Ports:
- MAX10_CLK1_50  in  1  system clock; every register is clocked on its rising edge.
- RESET  in  1  reset, synchronous, active-high.
- KEY_N  in  1  pushbutton, active-low, asynchronous to the clock, bouncy.
- SW  in  4  operand/mode switches, asynchronous, sampled only on a capture edge.
- input1  out  4  captured operand 1, feeds the comparator's `input1`.
- input2  out  4  captured operand 2, feeds the comparator's `input2`.
- scomp  out  2  mode: 2'b10 = unsigned, 2'b11 = signed; no other value is ever driven.
- valid  out  1  high while in S_READY.
- stage  out  2  current state encoding, for LEDR display.

## Operation

- KEY_N passes through a two-flop synchronizer, then a debouncer, then a falling-edge detector.
- The edge detector produces a one-cycle `press` pulse when the accepted level goes 1→0.
- Debouncer behaviour:
  - A counter increments while the synchronized level differs from the accepted level.
  - The counter clears to 0 whenever the two levels match.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the accepted level takes the synchronized level and the counter clears.
  - A bounce before that point restarts the count.
- Release (0→1) updates the accepted level but never produces `press`.
- Holding the button down yields exactly one press.
- FSM states, with `stage` values:
  - S_A (2'b00): on press, input1←SW; go to S_B.
  - S_B (2'b01): on press, input2←SW; go to S_MODE.
  - S_MODE (2'b10): on press, scomp←{1'b1, SW[0]}; go to S_READY.
  - S_READY (2'b11): valid=1. On press, go to S_A and drop valid. Operands hold their old values until they are overwritten.
- Without a press, the FSM stays in its state and every output holds.
- SW changes between presses have no effect.

## Timing

- Reset values: input1=0, input2=0, scomp=2'b10, valid=0, stage=S_A. Internal: both synchronizer flops=1, accepted level=1, counter=0.
- RESET has priority over a simultaneous press; nothing is captured on that edge.
- Reset mid-sequence returns to S_A and clears the operands.
- Capture latency, counting edge 1 as the first rising edge that samples KEY_N low (button stable low from then on):
  - The accepted level changes at edge DEBOUNCE_CYCLES+2.
  - The capture register, `stage` and `valid` update at edge DEBOUNCE_CYCLES+3.
- `valid` rises at the same edge at which scomp is written. All three outputs are therefore consistent whenever valid=1.
- Back-to-back presses need at least 2·DEBOUNCE_CYCLES+1 cycles of separation (release plus re-press).
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration

- OPERAND_LOADER_DEBOUNCE_EN defined:
  - Debouncer as described above.
  - Capture at edge DEBOUNCE_CYCLES+3.
- Not defined:
  - Counter removed; the accepted level is the synchronizer output.
  - Capture at edge 3; each bounce edge becomes a separate press.
  - DEBOUNCE_CYCLES is ignored.

## Structure

- Package `operand_loader_pkg` holds:
  - state encodings S_A, S_B, S_MODE, S_READY (2-bit);
  - SCOMP_UNSIGNED=2'b10 and SCOMP_SIGNED=2'b11;
  - the operand width constant 4.
- Counter width is $clog2(DEBOUNCE_CYCLES).
- One sub-module, `key_debounce`: synchronizer, debounce counter (macro-guarded) and falling-edge pulse output. It is instantiated once.
- The FSM and capture registers live in operand_loader.

## Test plan

Run with DEBOUNCE_CYCLES=4 unless noted.

1. RESET held 2 cycles, then released → input1=0, input2=0, scomp=2'b10, valid=0, stage=2'b00.
2. Three clean presses with SW=4'b0101, then 4'b1110, then 4'b0001 → input1=5, input2=4'hE, scomp=2'b11, valid=1, stage=2'b11. Each capture lands exactly 7 edges after its first low sample.
3. KEY_N bounces 0/1/0 at 1-cycle spacing, then is held low 20 cycles → exactly one capture. Timing restarts from the last 1→0 edge. Holding longer gives no second capture.
4. In S_READY, press with SW=4'b1111 → stage=2'b00, valid=0, and input1/input2/scomp unchanged.
5. RESET asserted on the same edge as a capture in S_B → no write, stage=2'b00, input1=0.
6. Macro undefined: 3-cycle low pulse → capture at edge 3. A 0/1/0 bounce → two presses, advancing S_A→S_B→S_MODE.
